// File: rtl/fig_pkg.sv
// Shared definitions for the figure RAM writer: FSM states, checksum width, RAM geometry.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fig_pkg;

  localparam int CHECKSUM_W     = 16;
  localparam int FIG_ADDR_WIDTH = 11;
  localparam int FIG_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } fig_state_e;

endpackage

// File: rtl/fig_rd_pipe.sv
// Tracks outstanding RAM reads through an RD_LATENCY-deep delay line and sums the returned words.
// Latency: a word is accumulated RD_LATENCY cycles after its read request.
// Backpressure: none; every returned word is consumed the cycle it arrives.
module fig_rd_pipe
  import fig_pkg::*;
#(
  parameter int DATA_WIDTH = FIG_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  clr_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [CHECKSUM_W-1:0] sum_o,
  output logic                  drained_o
);

  // Oldest stage of the delay line: only the last outstanding read may remain when drained.
  localparam logic [RD_LATENCY-1:0] LAST_MASK = RD_LATENCY'(1) << (RD_LATENCY - 1);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CHECKSUM_W-1:0] sum_q, sum_d;
  logic                  cap;

  // Shift the request flags and add the word whose request reaches the end of the line.
  always_comb begin
    vld_d = (vld_q << 1) | RD_LATENCY'(rd_en_i);
    cap   = vld_q[RD_LATENCY-1];
    sum_d = sum_q + (cap ? CHECKSUM_W'(rd_data_i) : '0);
  end

  // sum_o already includes the word captured this cycle, so the final compare needs no extra cycle.
  assign sum_o     = sum_d;
  assign drained_o = !rd_en_i && ((vld_q & ~LAST_MASK) == '0);

  // Delay-line and accumulator state; a new load clears both.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      vld_q <= '0;
      sum_q <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
      sum_q <= '0;
    end else begin
      vld_q <= vld_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/fig_ram_writer.sv
// Loads a byte stream into the figure RAM, then reads it all back and checks the sum.
// Latency: start to done is 1 + 2*2**ADDR_WIDTH + RD_LATENCY cycles with an unstalled stream.
// Backpressure: s_ready is high only in WRITE; stream gaps stall the write pass indefinitely.
module fig_ram_writer
  import fig_pkg::*;
#(
  parameter int ADDR_WIDTH = FIG_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIG_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CHECKSUM_W-1:0] checksum
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  fig_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CHECKSUM_W-1:0] checksum_q;
  logic                  err_q;

  logic                  start_ok;
  logic                  xfer;
  logic [CHECKSUM_W-1:0] rd_sum;
  logic                  rd_drained;

  // start is only honoured between loads.
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // The write port is driven straight from the handshake so a word lands in the cycle it is accepted.
  assign s_ready     = (state_q == ST_WRITE);
  assign xfer        = s_valid && s_ready;
  assign ram_wr_en   = xfer;
  assign ram_wr_data = xfer ? s_data : '0;
  assign ram_rd_en   = (state_q == ST_READ);
  assign ram_addr    = addr_q;

  assign busy     = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign checksum = checksum_q;

  fig_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .clr_i     (start_ok),
    .rd_en_i   (ram_rd_en),
    .rd_data_i (ram_rd_data),
    .sum_o     (rd_sum),
    .drained_o (rd_drained)
  );

  // Load sequencer: write pass, read-back pass, drain of in-flight reads, then verdict.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_WRITE;
            addr_q     <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (xfer) begin
            checksum_q <= checksum_q + CHECKSUM_W'(s_data);
            if (addr_q == ADDR_MAX) begin
              addr_q  <= '0;
              state_q <= ST_READ;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_READ: begin
          // Address parks at its maximum after the last read; it does not wrap.
          if (addr_q == ADDR_MAX) begin
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (rd_drained) begin
            err_q   <= (rd_sum != checksum_q);
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fig_ram_writer.sv
// Directed bench for fig_ram_writer: two instances (read latency 1 and 2) with behavioural RAMs.
// Both instances see the same stream; the latency-1 RAM can corrupt one word on readback.
// Inputs change on the falling edge, outputs are sampled away from the rising edge.
module tb_fig_ram_writer;

  logic       clk = 1'b0;
  logic       tb_rst = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       fault = 1'b0;

  logic        s_ready1, ram_wr_en1, ram_rd_en1, busy1, done1, err1;
  logic [3:0]  ram_addr1;
  logic [7:0]  ram_wr_data1, ram_rd_data1;
  logic [15:0] checksum1;

  logic        s_ready2, ram_wr_en2, ram_rd_en2, busy2, done2, err2;
  logic [3:0]  ram_addr2;
  logic [7:0]  ram_wr_data2, ram_rd_data2;
  logic [15:0] checksum2;

  int n_chk = 0;
  int n_fail = 0;

  // Results of the most recent run_load
  int         t1, t2, cyc;
  int         wr_cnt, rd_cnt, bad_wr, both_en;
  int         wr_addr [64];
  logic [7:0] wr_dat  [64];
  int         rd_addr [64];
  logic [1:0] at1;

  always #5 clk = ~clk;

  fig_ram_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .tb_rst(tb_rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready1), .ram_addr(ram_addr1), .ram_wr_en(ram_wr_en1), .ram_wr_data(ram_wr_data1),
    .ram_rd_en(ram_rd_en1), .ram_rd_data(ram_rd_data1), .busy(busy1), .done(done1),
    .err(err1), .checksum(checksum1)
  );

  fig_ram_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .tb_rst(tb_rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready2), .ram_addr(ram_addr2), .ram_wr_en(ram_wr_en2), .ram_wr_data(ram_wr_data2),
    .ram_rd_en(ram_rd_en2), .ram_rd_data(ram_rd_data2), .busy(busy2), .done(done2),
    .err(err2), .checksum(checksum2)
  );

  // RAM for the latency-1 instance, with optional corruption of address 5 on readback
  logic [7:0] mem1 [16];
  logic [7:0] r1a;
  always @(posedge clk) begin
    if (ram_wr_en1) mem1[ram_addr1] <= ram_wr_data1;
    if (ram_rd_en1) r1a <= mem1[ram_addr1] ^ ((fault && ram_addr1 == 4'd5) ? 8'h01 : 8'h00);
  end
  assign ram_rd_data1 = r1a;

  // RAM for the latency-2 instance: array read plus output register
  logic [7:0] mem2 [16];
  logic [7:0] r2a, r2b;
  always @(posedge clk) begin
    if (ram_wr_en2) mem2[ram_addr2] <= ram_wr_data2;
    if (ram_rd_en2) r2a <= mem2[ram_addr2];
    r2b <= r2a;
  end
  assign ram_rd_data2 = r2b;

  // Runs one load. pat 0: ramp 0..15 with s_valid held high; pat 1: 0xFF with s_valid 1,0,1,0...
  // inject pulses start during WRITE (cycle 5) and READ (cycle 20).
  task automatic run_load(input int pat, input bit inject);
    int idx;
    bit tog;
    idx = 0; tog = 1'b1;
    wr_cnt = 0; rd_cnt = 0; bad_wr = 0; both_en = 0;
    t1 = 0; t2 = 0; cyc = 0; at1 = 2'b11;
    @(negedge clk);
    start = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    while ((t1 == 0 || t2 == 0) && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = inject && (cyc == 5 || cyc == 20);
      if (cyc == 1) at1 = {done1, err1};
      if (t1 == 0 && done1) t1 = cyc;
      if (t2 == 0 && done2) t2 = cyc;
      if (pat == 0) begin
        s_valid = 1'b1;
        s_data  = idx[7:0];
      end else begin
        s_valid = tog;
        tog     = !tog;
        s_data  = 8'hFF;
      end
      #1;
      if (s_valid && s_ready1) idx++;
      if (ram_wr_en1 && wr_cnt < 64) begin
        wr_addr[wr_cnt] = int'(ram_addr1);
        wr_dat[wr_cnt]  = ram_wr_data1;
        wr_cnt++;
      end
      if (ram_wr_en1 && !s_valid) bad_wr++;
      if (ram_rd_en1 && rd_cnt < 64) begin
        rd_addr[rd_cnt] = int'(ram_addr1);
        rd_cnt++;
      end
      if ((ram_wr_en1 && ram_rd_en1) || (ram_wr_en2 && ram_rd_en2)) both_en++;
    end
    start = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 tb_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_ready1, ram_wr_en1, ram_rd_en1, busy1, done1, err1} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl1: got %b expected 000000", {s_ready1, ram_wr_en1, ram_rd_en1, busy1, done1, err1});
    end
    n_chk++;
    if ({s_ready2, ram_wr_en2, ram_rd_en2, busy2, done2, err2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl2: got %b expected 000000", {s_ready2, ram_wr_en2, ram_rd_en2, busy2, done2, err2});
    end
    n_chk++;
    if ({ram_addr1, ram_wr_data1, checksum1} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_data1: addr=%0h wdata=%0h csum=%0h expected all 0", ram_addr1, ram_wr_data1, checksum1);
    end
    tb_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    int bad;
    run_load(0, 1'b0);
    n_chk++;
    if (t1 !== 34) begin n_fail++; $display("FAIL ramp_time_lat1: got %0d expected 34", t1); end
    n_chk++;
    if (t2 !== 35) begin n_fail++; $display("FAIL ramp_time_lat2: got %0d expected 35", t2); end
    n_chk++;
    if (checksum1 !== 16'h0078 || checksum2 !== 16'h0078) begin
      n_fail++; $display("FAIL ramp_checksum: got %h/%h expected 0078", checksum1, checksum2);
    end
    n_chk++;
    if ({err1, err2, done1, done2, busy1} !== 5'b00110) begin
      n_fail++; $display("FAIL ramp_status: err=%b%b done=%b%b busy=%b expected err=00 done=11 busy=0", err1, err2, done1, done2, busy1);
    end
    n_chk++;
    if (wr_cnt !== 16 || rd_cnt !== 16) begin
      n_fail++; $display("FAIL ramp_counts: writes=%0d reads=%0d expected 16/16", wr_cnt, rd_cnt);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_addr[i] !== i || wr_dat[i] !== 8'(i) || rd_addr[i] !== i || mem1[i] !== 8'(i)) bad++;
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL ramp_addr_seq: %0d bad entries expected 0", bad); end
    n_chk++;
    if (both_en !== 0) begin n_fail++; $display("FAIL ramp_wr_rd_overlap: got %0d expected 0", both_en); end
  endtask

  task automatic test_backpressure();
    run_load(1, 1'b0);
    n_chk++;
    if (t1 == 0 || t2 == 0) begin n_fail++; $display("FAIL bp_done: t1=%0d t2=%0d expected nonzero", t1, t2); end
    n_chk++;
    if (wr_cnt !== 16) begin n_fail++; $display("FAIL bp_writes: got %0d expected 16", wr_cnt); end
    n_chk++;
    if (bad_wr !== 0) begin n_fail++; $display("FAIL bp_write_without_valid: got %0d expected 0", bad_wr); end
    n_chk++;
    if (checksum1 !== 16'h0FF0 || checksum2 !== 16'h0FF0) begin
      n_fail++; $display("FAIL bp_checksum: got %h/%h expected 0ff0", checksum1, checksum2);
    end
    n_chk++;
    if ({err1, err2} !== 2'b00) begin n_fail++; $display("FAIL bp_err: got %b expected 00", {err1, err2}); end
  endtask

  task automatic test_fault();
    fault = 1'b1;
    run_load(0, 1'b0);
    fault = 1'b0;
    n_chk++;
    if ({done1, err1} !== 2'b11) begin n_fail++; $display("FAIL fault_err: done,err=%b expected 11", {done1, err1}); end
    n_chk++;
    if (checksum1 !== 16'h0078) begin n_fail++; $display("FAIL fault_checksum: got %h expected 0078", checksum1); end
    n_chk++;
    if (err2 !== 1'b0) begin n_fail++; $display("FAIL fault_clean_instance: err=%b expected 0", err2); end
  endtask

  task automatic test_start_ignored();
    int bad;
    // Starts from DONE with err=1 left by the fault run
    run_load(0, 1'b1);
    n_chk++;
    if (at1 !== 2'b00) begin n_fail++; $display("FAIL restart_clears: done,err=%b expected 00", at1); end
    n_chk++;
    if (t1 !== 34 || t2 !== 35) begin n_fail++; $display("FAIL ign_time: got %0d/%0d expected 34/35", t1, t2); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (wr_addr[i] !== i || rd_addr[i] !== i) bad++;
    end
    n_chk++;
    if (bad !== 0 || wr_cnt !== 16 || rd_cnt !== 16) begin
      n_fail++; $display("FAIL ign_addr_seq: bad=%0d writes=%0d reads=%0d expected 0/16/16", bad, wr_cnt, rd_cnt);
    end
    n_chk++;
    if ({err1, err2} !== 2'b00 || checksum1 !== 16'h0078) begin
      n_fail++; $display("FAIL ign_result: err=%b csum=%h expected 00/0078", {err1, err2}, checksum1);
    end
  endtask

  task automatic test_mid_reset();
    int idx, guard;
    idx = 0; guard = 0;
    s_valid = 1'b1;
    while (idx < 7 && guard < 40) begin
      @(negedge clk);
      start  = (guard == 0);
      s_data = idx[7:0];
      #1;
      if (s_ready1) idx++;
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (checksum1 !== 16'h0015 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL midrst_before: csum=%h busy=%b expected 0015/1", checksum1, busy1);
    end
    tb_rst = 1'b1;
    #1;
    n_chk++;
    if ({s_ready1, ram_wr_en1, ram_rd_en1, busy1, done1, err1} !== 6'b0 || {ram_addr1, ram_wr_data1, checksum1} !== 28'h0) begin
      n_fail++;
      $display("FAIL midrst_async: ctrl=%b addr=%0h wdata=%0h csum=%0h expected all 0",
               {s_ready1, ram_wr_en1, ram_rd_en1, busy1, done1, err1}, ram_addr1, ram_wr_data1, checksum1);
    end
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
    run_load(0, 1'b0);
    n_chk++;
    if (checksum1 !== 16'h0078 || err1 !== 1'b0 || t1 !== 34) begin
      n_fail++; $display("FAIL midrst_reload: csum=%h err=%b t=%0d expected 0078/0/34", checksum1, err1, t1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_fault();
    test_start_ignored();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
